alu_operand_sequencer: RTL and testbench

Upstream operand-entry controller for the 32-bit ALU. It consumes single-value entries from the touch-screen module (`input_valid`/`input_value`) and steps through the five ALU control fields in a fixed order: OP1, OP2, F, DIR, BITE. It range-checks each entry, holds the fields stable while the ALU settles, then captures the ALU result into a result register with a one-cycle valid strobe. It replaces switch-based field selection; its field outputs drive the ALU operand/control ports directly.

---
 rtl/alu_operand_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand-entry sequencer for the 32-bit ALU: collects OP1/OP2/F/DIR/BITE entries,
// range-checks them, waits for the ALU to settle, then captures the result.
module alu_operand_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        input_valid,
  input  logic [31:0] input_value,
  input  logic        step_next,
  input  logic [31:0] alu_s,
  input  logic        alu_co,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [2:0]  op_f,
  output logic [1:0]  op_dir,
  output logic [4:0]  op_bite,
  output logic [2:0]  field_idx,
  output logic        err,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_co,
  output logic        result_valid,
  output logic [7:0]  txn_cnt
);

  typedef enum logic [2:0] {
    S_OP1  = 3'd0,
    S_OP2  = 3'd1,
    S_F    = 3'd2,
    S_DIR  = 3'd3,
    S_BITE = 3'd4,
    S_EXEC = 3'd5,
    S_HOLD = 3'd6
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [2:0]  op_f_q, op_f_d;
  logic [1:0]  op_dir_q, op_dir_d;
  logic [4:0]  op_bite_q, op_bite_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic        result_co_q, result_co_d;
  logic        result_valid_q, result_valid_d;
  logic [7:0]  txn_cnt_q, txn_cnt_d;
  logic [3:0]  settle_q, settle_d;

  logic   range_ok;
  state_t next_field;

  always_comb begin
    range_ok   = 1'b1;
    next_field = state_q;
    case (state_q)
      S_OP1:   next_field = S_OP2;
      S_OP2:   next_field = S_F;
      S_F: begin
        range_ok   = (input_value[31:3] == '0);
        next_field = S_DIR;
      end
      S_DIR: begin
        range_ok   = (input_value[31:2] == '0);
        next_field = S_BITE;
      end
      S_BITE: begin
        range_ok   = (input_value[31:5] == '0);
        next_field = S_EXEC;
      end
      default: next_field = state_q;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_f_d         = op_f_q;
    op_dir_d       = op_dir_q;
    op_bite_d      = op_bite_q;
    err_d          = err_q;
    result_d       = result_q;
    result_co_d    = result_co_q;
    result_valid_d = 1'b0;
    txn_cnt_d      = txn_cnt_q;
    // Counter is preloaded in every non-EXEC state, so any entry into EXEC starts fresh.
    settle_d       = (state_q == S_EXEC) ? settle_q : SETTLE_INIT;

    case (state_q)
      S_OP1, S_OP2, S_F, S_DIR, S_BITE: begin
        if (input_valid) begin
          if (range_ok) begin
            case (state_q)
              S_OP1:   op_a_d    = input_value;
              S_OP2:   op_b_d    = input_value;
              S_F:     op_f_d    = input_value[2:0];
              S_DIR:   op_dir_d  = input_value[1:0];
              S_BITE:  op_bite_d = input_value[4:0];
              default: ;
            endcase
            err_d   = 1'b0;
            state_d = next_field;
          end else begin
            err_d = 1'b1;
          end
        end else if (step_next) begin
          state_d = next_field;
        end
      end
      S_EXEC: begin
        if (settle_q == 4'd0) begin
          result_d       = alu_s;
          result_co_d    = alu_co;
          result_valid_d = 1'b1;
          txn_cnt_d      = txn_cnt_q + 8'd1;
          state_d        = S_HOLD;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (input_valid) begin
          op_a_d  = input_value;
          err_d   = 1'b0;
          state_d = S_OP2;
        end else if (step_next) begin
          state_d = S_OP1;
        end
      end
      default: state_d = S_OP1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_OP1;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_f_q         <= '0;
      op_dir_q       <= '0;
      op_bite_q      <= '0;
      err_q          <= 1'b0;
      result_q       <= '0;
      result_co_q    <= 1'b0;
      result_valid_q <= 1'b0;
      txn_cnt_q      <= '0;
      settle_q       <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_f_q         <= op_f_d;
      op_dir_q       <= op_dir_d;
      op_bite_q      <= op_bite_d;
      err_q          <= err_d;
      result_q       <= result_d;
      result_co_q    <= result_co_d;
      result_valid_q <= result_valid_d;
      txn_cnt_q      <= txn_cnt_d;
      settle_q       <= settle_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_f         = op_f_q;
  assign op_dir       = op_dir_q;
  assign op_bite      = op_bite_q;
  assign field_idx    = state_q;
  assign err          = err_q;
  assign busy         = (state_q == S_EXEC);
  assign result       = result_q;
  assign result_co    = result_co_q;
  assign result_valid = result_valid_q;
  assign txn_cnt      = txn_cnt_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: DUT 0 settles in 1 cycle, DUT 1 in 4 cycles;
// both use an adder as the ALU and a capture scoreboard per DUT.
module tb_alu_operand_sequencer;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic [7:0]  txn;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        input_valid [2];
  logic [31:0] input_value [2];
  logic        step_next [2];
  logic [31:0] alu_s [2];
  logic        alu_co [2];
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic [2:0]  op_f [2];
  logic [1:0]  op_dir [2];
  logic [4:0]  op_bite [2];
  logic [2:0]  field_idx [2];
  logic        err [2];
  logic        busy [2];
  logic [31:0] result [2];
  logic        result_co [2];
  logic        result_valid [2];
  logic [7:0]  txn_cnt [2];

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] exp_txn [2];
  logic prev_rv0 = 1'b0;
  logic prev_rv1 = 1'b0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_alu
    assign {alu_co[i], alu_s[i]} = {1'b0, op_a[i]} + {1'b0, op_b[i]};
  end

  alu_operand_sequencer #(.SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .input_valid(input_valid[0]), .input_value(input_value[0]), .step_next(step_next[0]),
    .alu_s(alu_s[0]), .alu_co(alu_co[0]),
    .op_a(op_a[0]), .op_b(op_b[0]), .op_f(op_f[0]), .op_dir(op_dir[0]), .op_bite(op_bite[0]),
    .field_idx(field_idx[0]), .err(err[0]), .busy(busy[0]),
    .result(result[0]), .result_co(result_co[0]), .result_valid(result_valid[0]),
    .txn_cnt(txn_cnt[0])
  );

  alu_operand_sequencer #(.SETTLE_CYCLES(4)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .input_valid(input_valid[1]), .input_value(input_value[1]), .step_next(step_next[1]),
    .alu_s(alu_s[1]), .alu_co(alu_co[1]),
    .op_a(op_a[1]), .op_b(op_b[1]), .op_f(op_f[1]), .op_dir(op_dir[1]), .op_bite(op_bite[1]),
    .field_idx(field_idx[1]), .err(err[1]), .busy(busy[1]),
    .result(result[1]), .result_co(result_co[1]), .result_valid(result_valid[1]),
    .txn_cnt(txn_cnt[1])
  );

  // Capture monitors: every result_valid pulse must match the oldest expected capture.
  always @(negedge clk) begin
    if (result_valid[0]) begin
      exp_t e;
      checks++;
      if (prev_rv0) begin
        errors++;
        $display("FAIL dut0_rv_consecutive: result_valid high two cycles");
      end else if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_capture: result=%h txn=%0d, no capture expected",
                 result[0], txn_cnt[0]);
      end else begin
        e = q0.pop_front();
        if ({result[0], result_co[0], txn_cnt[0]} !== {e.res, e.co, e.txn}) begin
          errors++;
          $display("FAIL dut0_capture: got res=%h co=%b txn=%0d, expected res=%h co=%b txn=%0d",
                   result[0], result_co[0], txn_cnt[0], e.res, e.co, e.txn);
        end
      end
    end
    prev_rv0 = result_valid[0];
  end

  always @(negedge clk) begin
    if (result_valid[1]) begin
      exp_t e;
      checks++;
      if (prev_rv1) begin
        errors++;
        $display("FAIL dut1_rv_consecutive: result_valid high two cycles");
      end else if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_capture: result=%h txn=%0d, no capture expected",
                 result[1], txn_cnt[1]);
      end else begin
        e = q1.pop_front();
        if ({result[1], result_co[1], txn_cnt[1]} !== {e.res, e.co, e.txn}) begin
          errors++;
          $display("FAIL dut1_capture: got res=%h co=%b txn=%0d, expected res=%h co=%b txn=%0d",
                   result[1], result_co[1], txn_cnt[1], e.res, e.co, e.txn);
        end
      end
    end
    prev_rv1 = result_valid[1];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input int d, input logic [31:0] v, input logic stp);
    input_valid[d] = 1'b1;
    input_value[d] = v;
    step_next[d]   = stp;
    tick();
    input_valid[d] = 1'b0;
    step_next[d]   = 1'b0;
  endtask

  task automatic step(input int d);
    step_next[d] = 1'b1;
    tick();
    step_next[d] = 1'b0;
  endtask

  task automatic push(input int d, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    {e.co, e.res} = {1'b0, a} + {1'b0, b};
    exp_txn[d] = exp_txn[d] + 8'd1;
    e.txn = exp_txn[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_capture(input int d);
    int n = 0;
    while (busy[d] && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL dut%0d_exec_timeout: busy=%b after %0d cycles, expected 0", d, busy[d], n);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    exp_txn[0] = 8'd0;
    exp_txn[1] = 8'd0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({op_a[d], op_b[d], op_f[d], op_dir[d], op_bite[d], field_idx[d], err[d], busy[d],
           result[d], result_co[d], result_valid[d], txn_cnt[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state_dut%0d: idx=%0d op_a=%h result=%h txn=%0d, expected all zero",
                 d, field_idx[d], op_a[d], result[d], txn_cnt[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] vals [5] = '{32'd5, 32'd3, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) push(0, 32'd5, 32'd3);
      enter(0, vals[i], 1'b0);
      checks++;
      if (field_idx[0] !== 3'(i + 1)) begin
        errors++;
        $display("FAIL basic_idx_step%0d: got %0d, expected %0d", i, field_idx[0], i + 1);
      end
    end
    checks++;
    if ({busy[0], op_a[0], op_b[0]} !== {1'b1, 32'd5, 32'd3}) begin
      errors++;
      $display("FAIL basic_exec: busy=%b op_a=%0d op_b=%0d, expected 1 5 3", busy[0], op_a[0], op_b[0]);
    end
    tick();
    checks++;
    if ({result_valid[0], field_idx[0], result[0], txn_cnt[0], busy[0]} !==
        {1'b1, 3'd6, 32'd8, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL basic_capture: rv=%b idx=%0d result=%0d txn=%0d busy=%b, expected 1 6 8 1 0",
               result_valid[0], field_idx[0], result[0], txn_cnt[0], busy[0]);
    end
    tick();
    checks++;
    if ({result_valid[0], field_idx[0], result[0]} !== {1'b0, 3'd6, 32'd8}) begin
      errors++;
      $display("FAIL basic_hold: rv=%b idx=%0d result=%0d, expected 0 6 8",
               result_valid[0], field_idx[0], result[0]);
    end
  endtask

  task automatic test_range();
    step(0);
    checks++;
    if ({field_idx[0], op_a[0]} !== {3'd0, 32'd5}) begin
      errors++;
      $display("FAIL range_hold_step: idx=%0d op_a=%0d, expected 0 5", field_idx[0], op_a[0]);
    end
    enter(0, 32'd1, 1'b0);
    enter(0, 32'd2, 1'b0);
    enter(0, 32'd8, 1'b0);
    checks++;
    if ({field_idx[0], err[0], op_f[0]} !== {3'd2, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL range_f_reject: idx=%0d err=%b f=%0d, expected 2 1 0", field_idx[0], err[0], op_f[0]);
    end
    enter(0, 32'd7, 1'b0);
    checks++;
    if ({field_idx[0], err[0], op_f[0]} !== {3'd3, 1'b0, 3'd7}) begin
      errors++;
      $display("FAIL range_f_accept: idx=%0d err=%b f=%0d, expected 3 0 7", field_idx[0], err[0], op_f[0]);
    end
    enter(0, 32'd4, 1'b0);
    checks++;
    if ({field_idx[0], err[0], op_dir[0]} !== {3'd3, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL range_dir_reject: idx=%0d err=%b dir=%0d, expected 3 1 0", field_idx[0], err[0], op_dir[0]);
    end
    enter(0, 32'd3, 1'b0);
    checks++;
    if ({field_idx[0], err[0], op_dir[0]} !== {3'd4, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL range_dir_accept: idx=%0d err=%b dir=%0d, expected 4 0 3", field_idx[0], err[0], op_dir[0]);
    end
    enter(0, 32'd32, 1'b0);
    checks++;
    if ({field_idx[0], err[0], op_bite[0]} !== {3'd4, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL range_bite_reject: idx=%0d err=%b bite=%0d, expected 4 1 0", field_idx[0], err[0], op_bite[0]);
    end
    push(0, 32'd1, 32'd2);
    enter(0, 32'd31, 1'b0);
    checks++;
    if ({field_idx[0], err[0], op_bite[0], busy[0]} !== {3'd5, 1'b0, 5'd31, 1'b1}) begin
      errors++;
      $display("FAIL range_bite_accept: idx=%0d err=%b bite=%0d busy=%b, expected 5 0 31 1",
               field_idx[0], err[0], op_bite[0], busy[0]);
    end
    wait_capture(0);
  endtask

  task automatic test_both();
    step(0);
    enter(0, 32'd10, 1'b1);
    checks++;
    if ({field_idx[0], op_a[0]} !== {3'd1, 32'd10}) begin
      errors++;
      $display("FAIL both_op1: idx=%0d op_a=%0d, expected 1 10", field_idx[0], op_a[0]);
    end
    enter(0, 32'd9, 1'b1);
    checks++;
    if ({field_idx[0], op_b[0]} !== {3'd2, 32'd9}) begin
      errors++;
      $display("FAIL both_op2: idx=%0d op_b=%0d, expected 2 9", field_idx[0], op_b[0]);
    end
    enter(0, 32'd8, 1'b1);
    checks++;
    if ({field_idx[0], err[0], op_f[0]} !== {3'd2, 1'b1, 3'd7}) begin
      errors++;
      $display("FAIL both_reject_no_advance: idx=%0d err=%b f=%0d, expected 2 1 7",
               field_idx[0], err[0], op_f[0]);
    end
    enter(0, 32'd1, 1'b0);
    step(0);
    checks++;
    if ({field_idx[0], op_dir[0], op_f[0], err[0]} !== {3'd4, 2'd3, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL both_step_dir: idx=%0d dir=%0d f=%0d err=%b, expected 4 3 1 0",
               field_idx[0], op_dir[0], op_f[0], err[0]);
    end
    push(0, 32'd10, 32'd9);
    enter(0, 32'd0, 1'b0);
    wait_capture(0);
  endtask

  task automatic test_hold_entry();
    enter(0, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if ({field_idx[0], op_a[0], result[0], err[0], result_valid[0]} !==
        {3'd1, 32'hFFFF_FFFF, 32'd19, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_entry: idx=%0d op_a=%h result=%0d err=%b rv=%b, expected 1 ffffffff 19 0 0",
               field_idx[0], op_a[0], result[0], err[0], result_valid[0]);
    end
    enter(0, 32'd1, 1'b0);
    step(0);
    step(0);
    push(0, 32'hFFFF_FFFF, 32'd1);
    enter(0, 32'd0, 1'b0);
    wait_capture(0);
  endtask

  task automatic test_settle4();
    int busy_cnt = 1;
    int cap_k = 0;
    enter(1, 32'd100, 1'b0);
    enter(1, 32'd23, 1'b0);
    enter(1, 32'd0, 1'b0);
    enter(1, 32'd0, 1'b0);
    push(1, 32'd100, 32'd23);
    enter(1, 32'd0, 1'b0);
    checks++;
    if ({busy[1], field_idx[1]} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL settle4_enter_exec: busy=%b idx=%0d, expected 1 5", busy[1], field_idx[1]);
    end
    for (int k = 1; k <= 12; k++) begin
      if (!busy[1]) break;
      input_valid[1] = k[0];
      input_value[1] = 32'h0000_DEAD;
      step_next[1]   = 1'b1;
      tick();
      input_valid[1] = 1'b0;
      step_next[1]   = 1'b0;
      if (busy[1]) busy_cnt++;
      else if (cap_k == 0) cap_k = k;
    end
    checks++;
    if (busy_cnt != 4 || cap_k != 4) begin
      errors++;
      $display("FAIL settle4_timing: busy_cycles=%0d capture_edge=+%0d, expected 4 and +4", busy_cnt, cap_k);
    end
    checks++;
    if ({op_a[1], op_b[1], op_f[1], op_dir[1], op_bite[1], field_idx[1]} !==
        {32'd100, 32'd23, 3'd0, 2'd0, 5'd0, 3'd6}) begin
      errors++;
      $display("FAIL settle4_fields: a=%0d b=%0d f=%0d dir=%0d bite=%0d idx=%0d, expected 100 23 0 0 0 6",
               op_a[1], op_b[1], op_f[1], op_dir[1], op_bite[1], field_idx[1]);
    end
  endtask

  task automatic test_wrap();
    for (int t = 0; t < 255; t++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      enter(1, a, 1'b0);
      enter(1, b, 1'b0);
      enter(1, 32'($urandom_range(0, 7)), 1'b0);
      enter(1, 32'($urandom_range(0, 3)), 1'b0);
      push(1, a, b);
      enter(1, 32'($urandom_range(0, 31)), 1'b0);
      wait_capture(1);
    end
    checks++;
    if (txn_cnt[1] !== 8'd0) begin
      errors++;
      $display("FAIL wrap_txn: txn_cnt=%0d after 256 transactions, expected 0", txn_cnt[1]);
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    enter(1, 32'd7, 1'b0);
    enter(1, 32'd6, 1'b0);
    enter(1, 32'd1, 1'b0);
    enter(1, 32'd2, 1'b0);
    enter(1, 32'd3, 1'b0);
    tick();
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstexec_busy: busy=%b, expected 1", busy[1]);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++;
    if ({op_a[1], op_b[1], op_f[1], op_dir[1], op_bite[1], field_idx[1], err[1], busy[1],
         result[1], result_co[1], result_valid[1], txn_cnt[1]} !== '0) begin
      errors++;
      $display("FAIL rstexec_state: idx=%0d op_a=%h busy=%b result=%h txn=%0d, expected all zero",
               field_idx[1], op_a[1], busy[1], result[1], txn_cnt[1]);
    end
    repeat (8) tick();
    checks++;
    if ({txn_cnt[1], field_idx[1], result[1]} !== {8'd0, 3'd0, 32'd0}) begin
      errors++;
      $display("FAIL rstexec_after: txn=%0d idx=%0d result=%h, expected 0 0 0",
               txn_cnt[1], field_idx[1], result[1]);
    end
  endtask

  initial begin
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      input_valid[d] = 1'b0;
      input_value[d] = '0;
      step_next[d]   = 1'b0;
      exp_txn[d]     = '0;
    end
    test_reset();
    test_basic();
    test_range();
    test_both();
    test_hold_entry();
    test_settle4();
    test_wrap();
    test_reset_exec();
    tick();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL missing_captures: pending dut0=%0d dut1=%0d, expected 0 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
